io_int_ctrl: RTL and testbench
==============================

IO_INT_CTRL -- requirements
Module: io_int_ctrl

Interface
REQ-001 Parameters SHALL be: ACK_CYCLES, 2, int_ack pulse length in cycles (>=1); SYNC_STAGES, 2, int_r synchronizer depth (>=1).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 io_req  in  1  CPU I/O access request, held until accepted.
REQ-005 io_we  in  1  1 = write, 0 = read; qualifies io_req.
REQ-006 io_addr  in  32  CPU byte address of the I/O word.
REQ-007 io_wdata  in  32  CPU write data.
REQ-008 io_rdata  out  32  captured read data; holds until next read completes.
REQ-009 io_done  out  1  one-cycle completion pulse.
REQ-010 io_busy  out  1  high whenever state != IDLE.
REQ-011 ie_set / ie_clr  in  1 each  interrupt-enable set/clear strobes (SETIE/CLRIE).
REQ-012 ie  out  1  interrupt-enable flag.
REQ-013 intr  out  1  interrupt request to CPU core.
REQ-014 intr_taken  in  1  CPU core accepts interrupt (one-cycle strobe).
REQ-015 cs, rd, wr  out  1 each  I/O memory chip select, read, write.
REQ-016 Addr  out  32  I/O memory address.
REQ-017 IO_In  out  32  data to I/O memory.
REQ-018 IO_Out  in  32  data from I/O memory (combinational, valid while cs&rd).
REQ-019 int_r  in  1  I/O device interrupt request (may be asynchronous).
REQ-020 int_ack  out  1  interrupt acknowledge to I/O device.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, INT_REQ, INT_ACK, WAIT_DROP.
REQ-022 int_r SHALL pass through SYNC_STAGES flops; int_s = last stage; all decisions use int_s only.
REQ-023 IDLE + io_req=1 SHALL latch io_addr, io_wdata, io_we and go to ACCESS; io_req has priority over a pending interrupt.
REQ-024 IDLE + io_req=0 + int_s=1 + ie=1 SHALL go to INT_REQ.
REQ-025 ACCESS (exactly one cycle): cs=1, wr=latched we, rd=!latched we, Addr/IO_In = latched values; never rd and wr both high.
REQ-026 Exit from ACCESS SHALL capture IO_Out into io_rdata (reads only), pulse io_done the following cycle, return to IDLE.
REQ-027 Latency: io_req sampled at edge N -> cs high cycle N..N+1 -> io_done high cycle N+1..N+2; one access per 2 cycles max.
REQ-028 Outside ACCESS: cs=rd=wr=0, Addr=0, IO_In=0.
REQ-029 io_req SHALL be ignored (not latched) when state != IDLE; CPU holds it.
REQ-030 INT_REQ: intr=1; intr_taken=1 -> ie<=0, go to INT_ACK; ie_clr=1 (without intr_taken) -> intr drops, go to IDLE, interrupt remains pending.
REQ-031 intr_taken and ie_clr in same INT_REQ cycle: intr_taken wins.
REQ-032 INT_ACK: int_ack=1 for exactly ACK_CYCLES cycles (counter), then WAIT_DROP.
REQ-033 WAIT_DROP: int_ack=0; stay until int_s=0, then IDLE; a stuck int_r SHALL never re-trigger.
REQ-034 ie: ie_set sets, ie_clr clears, simultaneous -> cleared; intr_taken clears; updates in any state.
REQ-035 intr SHALL be 0 in every state except INT_REQ.

Reset
REQ-036 reset=0 at an edge SHALL force IDLE, synchronizer and ACK counter to 0, ie=0, intr=0, int_ack=0, io_done=0, io_busy=0, cs=rd=wr=0, Addr=0, IO_In=0, io_rdata=0 -- including mid-ACCESS or mid-INT_ACK.
REQ-037 An access aborted by reset SHALL produce no io_done; no write occurs on the reset edge.

Verification
REQ-038 Write 0xDEADBEEF to 0x010 then read 0x010 -> cs&wr one cycle, io_done, cs&rd one cycle, io_rdata=0xDEADBEEF.
REQ-039 int_r=1 with ie=0 for 20 cycles -> intr=0; ie_set -> intr=1 one cycle later (IDLE->INT_REQ).
REQ-040 intr_taken in INT_REQ -> ie=0, int_ack=1 exactly 2 cycles, device drops int_r -> IDLE after SYNC_STAGES+1 cycles; int_r held high -> stays WAIT_DROP.
REQ-041 io_req and int_s rise same cycle with ie=1 -> ACCESS first, io_done pulse, intr=1 next cycle.
REQ-042 ie_clr during INT_REQ -> intr=0 next cycle, int_ack never asserts; ie_set again -> intr re-asserts.
REQ-043 reset=0 during ACCESS (write) -> next edge all outputs 0, no io_done, memory word unchanged.

Source files
------------

// File: rtl/io_int_ctrl_if.sv
// =============================================================================
// Module      : io_int_ctrl_if
// Description : CPU-side I/O access bus between the core and io_int_ctrl.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface io_int_ctrl_if;
  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_done;
  logic        io_busy;

  modport master (
    output io_req, io_we, io_addr, io_wdata,
    input  io_rdata, io_done, io_busy
  );

  modport slave (
    input  io_req, io_we, io_addr, io_wdata,
    output io_rdata, io_done, io_busy
  );
endinterface

`default_nettype wire

// File: rtl/io_int_ctrl.sv
// =============================================================================
// Module      : io_int_ctrl
// Description : Single-cycle I/O memory access engine plus device interrupt
//               request/acknowledge handshake with enable flag.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module io_int_ctrl #(
  parameter int ACK_CYCLES  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  io_int_ctrl_if.slave bus,
  input  logic        ie_set,
  input  logic        ie_clr,
  output logic        ie,
  output logic        intr,
  input  logic        intr_taken,
  output logic        cs,
  output logic        rd,
  output logic        wr,
  output logic [31:0] Addr,
  output logic [31:0] IO_In,
  input  logic [31:0] IO_Out,
  input  logic        int_r,
  output logic        int_ack
);

  localparam int c_CNT_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_ACK_LAST = c_CNT_W'(ACK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCESS    = 3'd1,
    INT_REQ   = 3'd2,
    INT_ACK   = 3'd3,
    WAIT_DROP = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 w_int_s;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic                 r_we;
  logic                 r_ie;
  logic                 r_done;
  logic [31:0]          r_rdata;
  logic [c_CNT_W-1:0]   r_ack_cnt;
  logic                 w_ack_last;
  logic                 w_access;

  generate
    if (SYNC_STAGES == 1) begin : g_sync_one
      always_ff @(posedge clk) begin
        if (!reset) r_sync <= '0;
        else        r_sync <= int_r;
      end
    end else begin : g_sync_multi
      always_ff @(posedge clk) begin
        if (!reset) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], int_r};
      end
    end
  endgenerate

  assign w_int_s    = r_sync[SYNC_STAGES-1];
  assign w_ack_last = (r_ack_cnt == c_ACK_LAST);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.io_req)            w_next = ACCESS;
        else if (w_int_s && r_ie)  w_next = INT_REQ;
      end
      ACCESS:    w_next = IDLE;
      INT_REQ: begin
        if (intr_taken)            w_next = INT_ACK;
        else if (ie_clr)           w_next = IDLE;
      end
      INT_ACK: begin
        if (w_ack_last)            w_next = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (!w_int_s)              w_next = IDLE;
      end
      default:                     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_ie      <= 1'b0;
      r_done    <= 1'b0;
      r_rdata   <= '0;
      r_ack_cnt <= '0;
    end else begin
      if (r_state == IDLE && bus.io_req) begin
        r_addr  <= bus.io_addr;
        r_wdata <= bus.io_wdata;
        r_we    <= bus.io_we;
      end
      r_done <= (r_state == ACCESS);
      if (r_state == ACCESS && !r_we) r_rdata <= IO_Out;
      if (ie_clr || intr_taken) r_ie <= 1'b0;
      else if (ie_set)          r_ie <= 1'b1;
      if (r_state == INT_ACK && !w_ack_last) r_ack_cnt <= r_ack_cnt + c_CNT_W'(1);
      else                                   r_ack_cnt <= '0;
    end
  end

  // Gating strobes with reset keeps the memory from writing on an aborting reset edge.
  assign w_access = (r_state == ACCESS) && reset;

  always_comb begin
    cs    = w_access;
    rd    = w_access && !r_we;
    wr    = w_access && r_we;
    Addr  = w_access ? r_addr  : 32'h0;
    IO_In = w_access ? r_wdata : 32'h0;
  end

  assign intr         = (r_state == INT_REQ);
  assign int_ack      = (r_state == INT_ACK);
  assign ie           = r_ie;
  assign bus.io_rdata = r_rdata;
  assign bus.io_done  = r_done;
  assign bus.io_busy  = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_io_int_ctrl.sv
// =============================================================================
// Module      : tb_io_int_ctrl
// Description : Randomized scenario bench for io_int_ctrl with a memory model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_io_int_ctrl;
  localparam int ACK  = 2;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        ie_set, ie_clr, ie, intr, intr_taken;
  logic        cs, rd, wr, int_r, int_ack;
  logic [31:0] Addr, IO_In, IO_Out;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [31:0] mem       [0:255];
  logic [31:0] model_mem [0:255];
  bit          written   [0:255];
  logic [31:0] model_rdata = 32'h0;

  io_int_ctrl_if bus();

  io_int_ctrl #(.ACK_CYCLES(ACK), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ie_set(ie_set), .ie_clr(ie_clr), .ie(ie), .intr(intr), .intr_taken(intr_taken),
    .cs(cs), .rd(rd), .wr(wr), .Addr(Addr), .IO_In(IO_In), .IO_Out(IO_Out),
    .int_r(int_r), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cs === 1'b1 && wr === 1'b1) mem[Addr[9:2]] <= IO_In;
  assign IO_Out = (cs && rd) ? mem[Addr[9:2]] : 32'h0;

  // Bus-level invariants sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if ((rd === 1'b1 && wr === 1'b1) ||
          (cs !== 1'b1 && (rd !== 1'b0 || wr !== 1'b0 || Addr !== 32'h0 || IO_In !== 32'h0)) ||
          (intr === 1'b1 && int_ack === 1'b1)) begin
        bad++;
        $display("FAIL monitor: cs=%b rd=%b wr=%b Addr=%h IO_In=%h intr=%b int_ack=%b, required idle bus zero and exclusive strobes",
                 cs, rd, wr, Addr, IO_In, intr, int_ack);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input bit we, input logic [7:0] idx, input logic [31:0] wd);
    logic [31:0] a;
    a = {22'h0, idx, 2'b00};
    bus.io_req = 1'b1; bus.io_we = we; bus.io_addr = a; bus.io_wdata = wd;
    cycle();
    total++;
    if (cs !== 1'b1 || wr !== we || rd !== !we || Addr !== a || IO_In !== wd ||
        bus.io_busy !== 1'b1 || bus.io_done !== 1'b0) begin
      bad++;
      $display("FAIL access_phase: cs=%b rd=%b wr=%b Addr=%h IO_In=%h busy=%b done=%b, required cs=1 rd=%b wr=%b Addr=%h IO_In=%h busy=1 done=0",
               cs, rd, wr, Addr, IO_In, bus.io_busy, bus.io_done, !we, we, a, wd);
    end
    bus.io_req = 1'b0; bus.io_addr = $urandom; bus.io_wdata = $urandom;
    if (we) begin model_mem[idx] = wd; written[idx] = 1'b1; end
    else model_rdata = model_mem[idx];
    cycle();
    total++;
    if (bus.io_done !== 1'b1 || cs !== 1'b0 || bus.io_busy !== 1'b0 || bus.io_rdata !== model_rdata) begin
      bad++;
      $display("FAIL done_phase: done=%b cs=%b busy=%b rdata=%h, required done=1 cs=0 busy=0 rdata=%h",
               bus.io_done, cs, bus.io_busy, bus.io_rdata, model_rdata);
    end
    cycle();
    total++;
    if (bus.io_done !== 1'b0) begin
      bad++;
      $display("FAIL done_width: done=%b, required 0", bus.io_done);
    end
  endtask

  // Take an interrupt from INT_REQ through to IDLE with the device releasing int_r.
  task automatic drain_int();
    int n;
    intr_taken = 1'b1;
    cycle();
    intr_taken = 1'b0;
    n = 0;
    while (int_ack === 1'b1 && n < 50) begin cycle(); n++; end
    int_r = 1'b0;
    n = 0;
    while (bus.io_busy !== 1'b0 && n < 50) begin cycle(); n++; end
    total++;
    if (bus.io_busy !== 1'b0 || intr !== 1'b0) begin
      bad++;
      $display("FAIL drain_timeout: busy=%b intr=%b, required 0 0", bus.io_busy, intr);
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.io_busy !== 1'b0 || bus.io_done !== 1'b0 || bus.io_rdata !== 32'h0 || ie !== 1'b0 ||
        intr !== 1'b0 || int_ack !== 1'b0 || cs !== 1'b0 || rd !== 1'b0 || wr !== 1'b0 ||
        Addr !== 32'h0 || IO_In !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b rdata=%h ie=%b intr=%b ack=%b cs=%b rd=%b wr=%b Addr=%h IO_In=%h, required all 0",
               bus.io_busy, bus.io_done, bus.io_rdata, ie, intr, int_ack, cs, rd, wr, Addr, IO_In);
    end
  endtask

  task automatic test_write_read();
    do_access(1'b1, 8'h04, 32'hDEADBEEF);
    do_access(1'b0, 8'h04, 32'h0);
    total++;
    if (bus.io_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL wr_rd_0x010: rdata=%h, required deadbeef", bus.io_rdata);
    end
  endtask

  task automatic test_random_access();
    for (int i = 0; i < 24; i++) begin
      logic [7:0] idx;
      bit we;
      idx = 8'($urandom_range(0, 15));
      we  = ($urandom_range(0, 1) == 1) || !written[idx];
      do_access(we, idx, $urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v1, v2;
    v1 = $urandom; v2 = $urandom;
    bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 32'h0000_0080; bus.io_wdata = v1;
    cycle();
    bus.io_addr = 32'h0000_0084; bus.io_wdata = v2;
    cycle();
    total++;
    if (bus.io_done !== 1'b1 || cs !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap: done=%b cs=%b, required 1 0", bus.io_done, cs);
    end
    cycle();
    total++;
    if (cs !== 1'b1 || Addr !== 32'h0000_0084 || IO_In !== v2) begin
      bad++;
      $display("FAIL b2b_second: cs=%b Addr=%h IO_In=%h, required 1 00000084 %h", cs, Addr, IO_In, v2);
    end
    bus.io_req = 1'b0;
    cycle();
    cycle();
    model_mem[32] = v1; written[32] = 1'b1;
    model_mem[33] = v2; written[33] = 1'b1;
    do_access(1'b0, 8'd32, 32'h0);
    do_access(1'b0, 8'd33, 32'h0);
  endtask

  task automatic test_ie_flag();
    bit m_ie;
    m_ie = ie;
    int_r = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bit s, c;
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      ie_set = s; ie_clr = c;
      cycle();
      ie_set = 1'b0; ie_clr = 1'b0;
      if (c) m_ie = 1'b0;
      else if (s) m_ie = 1'b1;
      total++;
      if (ie !== m_ie) begin
        bad++;
        $display("FAIL ie_flag: set=%b clr=%b ie=%b, required %b", s, c, ie, m_ie);
      end
    end
  endtask

  task automatic test_ie_gate();
    ie_clr = 1'b1; cycle(); ie_clr = 1'b0;
    int_r = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      total++;
      if (intr !== 1'b0 || bus.io_busy !== 1'b0) begin
        bad++;
        $display("FAIL ie_gate: intr=%b busy=%b, required 0 0", intr, bus.io_busy);
      end
    end
    ie_set = 1'b1; cycle(); ie_set = 1'b0;
    total++;
    if (ie !== 1'b1 || intr !== 1'b0) begin
      bad++;
      $display("FAIL ie_set_edge: ie=%b intr=%b, required 1 0", ie, intr);
    end
    cycle();
    total++;
    if (intr !== 1'b1 || int_ack !== 1'b0 || bus.io_busy !== 1'b1) begin
      bad++;
      $display("FAIL intr_rise: intr=%b ack=%b busy=%b, required 1 0 1", intr, int_ack, bus.io_busy);
    end
  endtask

  task automatic test_int_service();
    int n, hold;
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      cycle();
      total++;
      if (intr !== 1'b1) begin
        bad++;
        $display("FAIL intr_hold: intr=%b, required 1", intr);
      end
    end
    intr_taken = 1'b1;
    cycle();
    intr_taken = 1'b0;
    total++;
    if (ie !== 1'b0 || int_ack !== 1'b1 || intr !== 1'b0) begin
      bad++;
      $display("FAIL taken: ie=%b ack=%b intr=%b, required 0 1 0", ie, int_ack, intr);
    end
    n = 0;
    while (int_ack === 1'b1 && n < 50) begin n++; cycle(); end
    total++;
    if (n != ACK) begin
      bad++;
      $display("FAIL ack_len: cycles=%0d, required %0d", n, ACK);
    end
    // int_r stuck high: request attempts must be ignored while parked
    hold = $urandom_range(3, 8);
    bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 32'h0000_0000; bus.io_wdata = $urandom;
    for (int i = 0; i < hold; i++) begin
      cycle();
      total++;
      if (cs !== 1'b0 || int_ack !== 1'b0 || intr !== 1'b0 || bus.io_busy !== 1'b1) begin
        bad++;
        $display("FAIL wait_drop: cs=%b ack=%b intr=%b busy=%b, required 0 0 0 1", cs, int_ack, intr, bus.io_busy);
      end
    end
    bus.io_req = 1'b0;
    int_r = 1'b0;
    n = 0;
    do begin cycle(); n++; end while (bus.io_busy !== 1'b0 && n < 20);
    total++;
    if (n != SYNC + 1) begin
      bad++;
      $display("FAIL drop_latency: cycles=%0d, required %0d", n, SYNC + 1);
    end
  endtask

  task automatic test_priority();
    ie_set = 1'b1; cycle(); ie_set = 1'b0;
    int_r = 1'b1;
    repeat (SYNC) cycle();
    bus.io_req = 1'b1; bus.io_we = 1'b0; bus.io_addr = 32'h0000_0010; bus.io_wdata = 32'h0;
    cycle();
    bus.io_req = 1'b0;
    total++;
    if (cs !== 1'b1 || rd !== 1'b1 || intr !== 1'b0) begin
      bad++;
      $display("FAIL prio_access: cs=%b rd=%b intr=%b, required 1 1 0", cs, rd, intr);
    end
    cycle();
    total++;
    if (bus.io_done !== 1'b1 || intr !== 1'b0 || bus.io_rdata !== model_mem[4]) begin
      bad++;
      $display("FAIL prio_done: done=%b intr=%b rdata=%h, required 1 0 %h", bus.io_done, intr, bus.io_rdata, model_mem[4]);
    end
    model_rdata = model_mem[4];
    cycle();
    total++;
    if (intr !== 1'b1) begin
      bad++;
      $display("FAIL prio_intr: intr=%b, required 1", intr);
    end
    drain_int();
  endtask

  task automatic test_ie_clr();
    int n;
    ie_set = 1'b1; cycle(); ie_set = 1'b0;
    int_r = 1'b1;
    n = 0;
    while (intr !== 1'b1 && n < 20) begin cycle(); n++; end
    ie_clr = 1'b1; cycle(); ie_clr = 1'b0;
    total++;
    if (intr !== 1'b0 || ie !== 1'b0 || bus.io_busy !== 1'b0) begin
      bad++;
      $display("FAIL ie_clr_drop: intr=%b ie=%b busy=%b, required 0 0 0", intr, ie, bus.io_busy);
    end
    n = $urandom_range(2, 6);
    for (int i = 0; i < n; i++) begin
      cycle();
      total++;
      if (intr !== 1'b0 || int_ack !== 1'b0) begin
        bad++;
        $display("FAIL ie_clr_idle: intr=%b ack=%b, required 0 0", intr, int_ack);
      end
    end
    ie_set = 1'b1; cycle(); ie_set = 1'b0;
    cycle();
    total++;
    if (intr !== 1'b1) begin
      bad++;
      $display("FAIL reassert: intr=%b, required 1", intr);
    end
    intr_taken = 1'b1; ie_clr = 1'b1;
    cycle();
    intr_taken = 1'b0; ie_clr = 1'b0;
    total++;
    if (int_ack !== 1'b1 || ie !== 1'b0 || intr !== 1'b0) begin
      bad++;
      $display("FAIL taken_wins: ack=%b ie=%b intr=%b, required 1 0 0", int_ack, ie, intr);
    end
    n = 0;
    while (int_ack === 1'b1 && n < 50) begin cycle(); n++; end
    int_r = 1'b0;
    n = 0;
    while (bus.io_busy !== 1'b0 && n < 50) begin cycle(); n++; end
    total++;
    if (bus.io_busy !== 1'b0) begin
      bad++;
      $display("FAIL clr_drain: busy=%b, required 0", bus.io_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  idx;
    logic [31:0] v1;
    int n;
    idx = 8'($urandom_range(64, 127));
    v1  = $urandom;
    do_access(1'b1, idx, v1);
    do_access(1'b0, idx, 32'h0);
    bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = {22'h0, idx, 2'b00}; bus.io_wdata = ~v1;
    cycle();
    reset = 1'b0; bus.io_req = 1'b0;
    cycle();
    total++;
    if (cs !== 1'b0 || wr !== 1'b0 || rd !== 1'b0 || Addr !== 32'h0 || IO_In !== 32'h0 ||
        bus.io_done !== 1'b0 || bus.io_busy !== 1'b0 || bus.io_rdata !== 32'h0 || ie !== 1'b0) begin
      bad++;
      $display("FAIL reset_access: cs=%b wr=%b rd=%b Addr=%h IO_In=%h done=%b busy=%b rdata=%h ie=%b, required all 0",
               cs, wr, rd, Addr, IO_In, bus.io_done, bus.io_busy, bus.io_rdata, ie);
    end
    reset = 1'b1;
    model_rdata = 32'h0;
    cycle();
    total++;
    if (bus.io_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done: done=%b, required 0", bus.io_done);
    end
    do_access(1'b0, idx, 32'h0);
    // Abort an interrupt acknowledge mid-pulse
    ie_set = 1'b1; cycle(); ie_set = 1'b0;
    int_r = 1'b1;
    n = 0;
    while (intr !== 1'b1 && n < 20) begin cycle(); n++; end
    intr_taken = 1'b1; cycle(); intr_taken = 1'b0;
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    total++;
    if (int_ack !== 1'b0 || bus.io_busy !== 1'b0 || ie !== 1'b0 || intr !== 1'b0) begin
      bad++;
      $display("FAIL reset_ack: ack=%b busy=%b ie=%b intr=%b, required all 0", int_ack, bus.io_busy, ie, intr);
    end
    repeat (SYNC + 2) cycle();
    total++;
    if (intr !== 1'b0 || bus.io_busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_int: intr=%b busy=%b, required 0 0", intr, bus.io_busy);
    end
    int_r = 1'b0;
    repeat (SYNC + 1) cycle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin model_mem[i] = 32'h0; written[i] = 1'b0; end
    reset = 1'b0; ie_set = 1'b0; ie_clr = 1'b0; intr_taken = 1'b0; int_r = 1'b0;
    bus.io_req = 1'b0; bus.io_we = 1'b0; bus.io_addr = 32'h0; bus.io_wdata = 32'h0;
    repeat (3) cycle();
    test_reset();
    reset = 1'b1;
    cycle();
    mon_en = 1'b1;
    test_reset();
    test_write_read();
    test_random_access();
    test_back_to_back();
    test_ie_flag();
    test_ie_gate();
    test_int_service();
    test_priority();
    test_ie_clr();
    test_reset_mid();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
